// File: rtl/lane_pipe_pkg.sv
// Shared stage-state encoding, default sizes and flattened-bus slice helper for lane_pipe.
// Optional per-lane transfer counters are enabled with LANE_PIPE_STATS_EN.
`ifndef LANE_PIPE_SLICE
`define LANE_PIPE_SLICE(bus, idx, w) bus[(idx)*(w) +: (w)]
`endif

package lane_pipe_pkg;

  localparam int unsigned DefWidth    = 8;
  localparam int unsigned DefChannels = 2;
  localparam int unsigned DefDepth    = 2;
  localparam int unsigned DefCountW   = 16;

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StFull  = 2'd2
  } stage_state_e;

  function automatic stage_state_e stage_state(input logic main_v, input logic skid_v);
    if (skid_v) return StFull;
    if (main_v) return StOne;
    return StEmpty;
  endfunction

endpackage

// File: rtl/lane_pipe_stage.sv
// One valid/ready register slice with a skid register; upstream ready comes from a flop only.
module lane_pipe_stage
  import lane_pipe_pkg::*;
#(
  parameter int unsigned Width = DefWidth
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [Width-1:0] data_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [Width-1:0] data_o
);

  logic             main_v_q, main_v_d;
  logic             skid_v_q, skid_v_d;
  logic [Width-1:0] main_q, main_d;
  logic [Width-1:0] skid_q, skid_d;
  logic             ready_q;
  logic             accept;
  logic             take;
  stage_state_e     state;

  assign state   = stage_state(main_v_q, skid_v_q);
  // Reset gating keeps ready low during reset even before the first edge.
  assign ready_o = ready_q & rst_ni;
  assign accept  = valid_i & ready_o;
  assign take    = main_v_q & ready_i;
  assign valid_o = main_v_q;
  assign data_o  = main_q;

  always_comb begin
    main_v_d = main_v_q;
    skid_v_d = skid_v_q;
    main_d   = main_q;
    skid_d   = skid_q;
    case (state)
      StEmpty: begin
        if (accept) begin
          main_v_d = 1'b1;
          main_d   = data_i;
        end
      end
      StOne: begin
        if (accept && take) begin
          main_d = data_i;
        end else if (accept) begin
          skid_v_d = 1'b1;
          skid_d   = data_i;
        end else if (take) begin
          main_v_d = 1'b0;
        end
      end
      StFull: begin
        if (take) begin
          main_d   = skid_q;
          skid_v_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      main_v_q <= 1'b0;
      skid_v_q <= 1'b0;
      main_q   <= '0;
      skid_q   <= '0;
      ready_q  <= 1'b0;
    end else begin
      main_v_q <= main_v_d;
      skid_v_q <= skid_v_d;
      main_q   <= main_d;
      skid_q   <= skid_d;
      ready_q  <= ~skid_v_d;
    end
  end

endmodule

// File: rtl/lane_pipe.sv
// CHANNELS independent lanes, each a chain of DEPTH skid slices (DEPTH=0 is pure wires).
// Define LANE_PIPE_STATS_EN to add per-lane output transfer counters on stat_count.
module lane_pipe
  import lane_pipe_pkg::*;
#(
  parameter int unsigned WIDTH    = DefWidth,
  parameter int unsigned CHANNELS = DefChannels,
  parameter int unsigned DEPTH    = DefDepth,
  parameter int unsigned COUNT_W  = DefCountW
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  output logic [CHANNELS-1:0]       out_valid,
  input  logic [CHANNELS-1:0]       out_ready,
  output logic [CHANNELS*WIDTH-1:0] out_data
`ifdef LANE_PIPE_STATS_EN
  ,
  output logic [CHANNELS*COUNT_W-1:0] stat_count
`endif
);

  for (genvar l = 0; l < CHANNELS; l++) begin : g_lane
    if (DEPTH == 0) begin : g_bypass
      assign out_valid[l]                        = in_valid[l];
      assign in_ready[l]                         = out_ready[l];
      assign `LANE_PIPE_SLICE(out_data, l, WIDTH) = `LANE_PIPE_SLICE(in_data, l, WIDTH);
    end else begin : g_pipe
      logic [DEPTH:0]   v;
      logic [DEPTH:0]   r;
      logic [WIDTH-1:0] d [DEPTH+1];

      assign v[0]        = in_valid[l];
      assign d[0]        = `LANE_PIPE_SLICE(in_data, l, WIDTH);
      assign in_ready[l] = r[0];

      for (genvar s = 0; s < DEPTH; s++) begin : g_stage
        lane_pipe_stage #(
          .Width(WIDTH)
        ) u_stage (
          .clk_i  (clk),
          .rst_ni (rst_n),
          .valid_i(v[s]),
          .ready_o(r[s]),
          .data_i (d[s]),
          .valid_o(v[s+1]),
          .ready_i(r[s+1]),
          .data_o (d[s+1])
        );
      end

      assign out_valid[l]                         = v[DEPTH];
      assign r[DEPTH]                             = out_ready[l];
      assign `LANE_PIPE_SLICE(out_data, l, WIDTH) = d[DEPTH];
    end
  end

  if (DEPTH == 0) begin : g_no_state
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;
  end

`ifdef LANE_PIPE_STATS_EN
  for (genvar l = 0; l < CHANNELS; l++) begin : g_stat
    logic [COUNT_W-1:0] cnt_q, cnt_d;

    assign cnt_d = (out_valid[l] && out_ready[l]) ? cnt_q + COUNT_W'(1) : cnt_q;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign `LANE_PIPE_SLICE(stat_count, l, COUNT_W) = cnt_q;
  end
`else
  // Counters compiled out; keep COUNT_W referenced.
  logic [COUNT_W-1:0] unused_count_w;
  assign unused_count_w = '0;
`endif

endmodule

// File: tb/tb_lane_pipe.sv
// Directed and random checks of lane_pipe (DEPTH=2) with a per-lane scoreboard, plus a DEPTH=0 copy.
module tb_lane_pipe;

  localparam int unsigned W  = 8;
  localparam int unsigned C  = 2;
  localparam int unsigned D  = 2;
  localparam int unsigned CW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n;
  logic [C-1:0]   in_valid, in_ready, out_valid, out_ready;
  logic [C*W-1:0] in_data, out_data;
  logic [C-1:0]   b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [C*W-1:0] b_in_data, b_out_data;
`ifdef LANE_PIPE_STATS_EN
  logic [C*CW-1:0] stat_count, b_stat_count;
`endif

  lane_pipe #(.WIDTH(W), .CHANNELS(C), .DEPTH(D), .COUNT_W(CW)) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
`ifdef LANE_PIPE_STATS_EN
    ,
    .stat_count(stat_count)
`endif
  );

  lane_pipe #(.WIDTH(W), .CHANNELS(C), .DEPTH(0), .COUNT_W(CW)) u_byp (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (b_in_valid),
    .in_ready (b_in_ready),
    .in_data  (b_in_data),
    .out_valid(b_out_valid),
    .out_ready(b_out_ready),
    .out_data (b_out_data)
`ifdef LANE_PIPE_STATS_EN
    ,
    .stat_count(b_stat_count)
`endif
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic [W-1:0] sb0[$], sb1[$];
  int ts0[$], ts1[$];
  int n_out[C];
  int acc[C];
  int cnt_model[C];
  bit lat_chk = 1'b0;
  logic [C-1:0]   prev_v = '0, prev_r = '0, stall_in = '0;
  logic [C*W-1:0] prev_d = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Samples handshakes mid-cycle, updates the scoreboard, then advances past the next edge.
  task automatic tick();
    logic [W-1:0] e;
    int t;
    @(negedge clk);
    cyc++;
    for (int l = 0; l < C; l++) begin
      stall_in[l] = in_valid[l] & ~in_ready[l];
      if (!rst_n) continue;
      if (prev_v[l] && !prev_r[l]) begin
        chk("hold_valid", 32'(out_valid[l]), 32'd1);
        chk("hold_data", 32'(out_data[l*W +: W]), 32'(prev_d[l*W +: W]));
      end
      if (in_valid[l] && in_ready[l]) begin
        acc[l]++;
        if (l == 0) begin sb0.push_back(in_data[l*W +: W]); ts0.push_back(cyc); end
        else begin sb1.push_back(in_data[l*W +: W]); ts1.push_back(cyc); end
      end
      if (out_valid[l] && out_ready[l]) begin
        chk("sb_has_entry", 32'((l == 0) ? (sb0.size() > 0) : (sb1.size() > 0)), 32'd1);
        if ((l == 0 && sb0.size() > 0) || (l == 1 && sb1.size() > 0)) begin
          if (l == 0) begin e = sb0.pop_front(); t = ts0.pop_front(); end
          else begin e = sb1.pop_front(); t = ts1.pop_front(); end
          chk("out_data", 32'(out_data[l*W +: W]), 32'(e));
          if (lat_chk) chk("latency", 32'(cyc - t), 32'(D));
        end
        n_out[l]++;
        cnt_model[l]++;
      end
    end
    prev_v = rst_n ? out_valid : '0;
    prev_r = out_ready;
    prev_d = out_data;
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int l = 0; l < C; l++) begin
      n_out[l] = 0; acc[l] = 0; cnt_model[l] = 0;
    end
    rst_n = 1'b0; in_valid = '0; in_data = '0; out_ready = '0;
    b_in_valid = '0; b_in_data = '0; b_out_ready = '0;
    repeat (3) tick();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b1; out_ready = 2'b11;
    tick();
    chk("ready_after_release", 32'(in_ready), 32'h3);

    // Unstalled stream on lane 0.
    lat_chk = 1'b1;
    for (int k = 0; k < 16; k++) begin
      in_valid = 2'b01;
      in_data  = {8'h00, 8'(k)};
      chk("stream_in_ready", 32'(in_ready[0]), 32'd1);
      tick();
      chk("lane1_idle", 32'(out_valid[1]), 32'd0);
    end
    in_valid = '0;
    repeat (4) tick();
    lat_chk = 1'b0;
    chk("stream_drained", 32'(sb0.size()), 32'd0);
    chk("stream_count", 32'(n_out[0]), 32'd16);

    // Stall lane 0 while lane 1 keeps flowing.
    acc[0] = 0; acc[1] = 0;
    out_ready = 2'b10; in_valid = 2'b11; in_data = {8'h80, 8'h40};
    for (int k = 0; k < 8; k++) begin
      tick();
      for (int l = 0; l < C; l++) if (!stall_in[l]) in_data[l*W +: W] = in_data[l*W +: W] + 8'd1;
    end
    chk("stall_accepts", 32'(acc[0]), 32'd4);
    chk("stall_in_ready", 32'(in_ready[0]), 32'd0);
    chk("lane1_accepts", 32'(acc[1]), 32'd8);
    chk("lane1_ready", 32'(in_ready[1]), 32'd1);
    in_valid = '0; out_ready = 2'b11;
    for (int k = 0; k < 12; k++) tick();
    chk("stall_drain0", 32'(sb0.size()), 32'd0);
    chk("stall_drain1", 32'(sb1.size()), 32'd0);

    // Reset with three beats buffered on lane 0.
    out_ready = 2'b00; in_valid = 2'b01; in_data = {8'h00, 8'hC0};
    for (int k = 0; k < 3; k++) begin
      tick();
      in_data[7:0] = in_data[7:0] + 8'd1;
    end
    in_valid = '0;
    chk("buffered_valid", 32'(out_valid[0]), 32'd1);
    rst_n = 1'b0;
    tick();
    sb0.delete(); sb1.delete(); ts0.delete(); ts1.delete();
    cnt_model[0] = 0; cnt_model[1] = 0;
    rst_n = 1'b1; out_ready = 2'b11;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_out_data", 32'(out_data), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    tick();
    chk("midrst_ready_back", 32'(in_ready), 32'h3);
    repeat (6) tick();
    chk("no_stale_valid", 32'(out_valid), 32'd0);

    // Random valid/ready traffic on both lanes.
    for (int k = 0; k < 10000; k++) begin
      for (int l = 0; l < C; l++) begin
        if (!stall_in[l]) begin
          in_valid[l]        = 1'($urandom_range(0, 1));
          in_data[l*W +: W]  = 8'($urandom);
        end
      end
      out_ready = 2'($urandom);
      tick();
    end
    out_ready = 2'b11;
    for (int k = 0; k < 40; k++) begin
      for (int l = 0; l < C; l++) if (!stall_in[l]) in_valid[l] = 1'b0;
      tick();
    end
    chk("rand_drain0", 32'(sb0.size()), 32'd0);
    chk("rand_drain1", 32'(sb1.size()), 32'd0);

`ifdef LANE_PIPE_STATS_EN
    for (int l = 0; l < C; l++)
      chk("stat_count", 32'(stat_count[l*CW +: CW]), 32'(cnt_model[l] & 32'hFFFF));
`endif

    // DEPTH=0 copy is purely combinational.
    b_in_data = 16'h5AA5; b_in_valid = 2'b01; b_out_ready = 2'b00;
    #1;
    chk("byp_data", 32'(b_out_data), 32'h5AA5);
    chk("byp_valid", 32'(b_out_valid), 32'h1);
    chk("byp_ready0", 32'(b_in_ready), 32'h0);
    b_out_ready = 2'b10; b_in_valid = 2'b10; b_in_data = 16'h3C00;
    #1;
    chk("byp_ready1", 32'(b_in_ready), 32'h2);
    chk("byp_valid1", 32'(b_out_valid), 32'h2);
    chk("byp_data1", 32'(b_out_data), 32'h3C00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
